// File: rtl/gtx_tx.sv
// gtx_tx: GTX transmit framer.
// After reset it sends ALIGN_LEN comma words (K28.5 pair, 16'hBCBC), then
// raises link_up_o and forwards payload words. It inserts idle commas when no
// payload is available, and forces one comma after COMMA_PERIOD consecutive
// data words.
// Optional build macro GTX_TX_FIFO_EN adds a 4-entry input FIFO. It decouples
// data_rdy_o from the framer state, giving a transfer-to-output latency of 2.
// Without it, payload is taken straight from data_i with latency 1.
// The state register describes what the *next* output word will be, because
// ctrl_o/data_o are registered. The FSM therefore leaves ALIGN one cycle
// before the last align comma is on the wire, and the first data word directly
// follows the ALIGN_LEN-th comma. This assumes ALIGN_LEN >= 2.
module gtx_tx #(
    parameter int ALIGN_LEN    = 16,
    parameter int COMMA_PERIOD = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] data_i,
    input  logic        data_vld_i,
    output logic        data_rdy_o,
    output logic [1:0]  ctrl_o,
    output logic [15:0] data_o,
    output logic        link_up_o
);

    localparam int AW = $clog2(ALIGN_LEN) + 1;
    localparam int RW = $clog2(COMMA_PERIOD) + 1;
    localparam logic [AW-1:0] ALIGN_LAST = AW'((ALIGN_LEN > 1) ? (ALIGN_LEN - 2) : 0);
    localparam logic [RW-1:0] RUN_MAX    = RW'(COMMA_PERIOD);
    localparam logic [15:0]   COMMA_WORD = 16'hBCBC;
    localparam logic [1:0]    CTRL_K     = 2'b11;
    localparam logic [1:0]    CTRL_D     = 2'b00;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_DATA  = 2'd1,
        ST_COMMA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   align_cnt_q, align_cnt_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [15:0]     data_q, data_d;
    logic            link_q, link_d;

    logic            word_avail_s;
    logic [15:0]     word_s;
    logic            take_s;

`ifdef GTX_TX_FIFO_EN
    logic [15:0]     fifo_mem_q [4];
    logic [1:0]      wr_ptr_q;
    logic [1:0]      rd_ptr_q;
    logic [2:0]      count_q;
    logic            full_s;
    logic            push_s;

    assign full_s       = (count_q == 3'd4);
    assign push_s       = data_vld_i && !full_s && rst_n_i;
    assign data_rdy_o   = !full_s && rst_n_i;
    assign word_avail_s = (count_q != 3'd0);
    assign word_s       = fifo_mem_q[rd_ptr_q];

    // Input FIFO storage, pointers and occupancy (push and pop may coincide).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 16'h0000;
            end
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (take_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_s, take_s})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    assign word_avail_s = data_vld_i;
    assign word_s       = data_i;
    assign data_rdy_o   = (state_q == ST_DATA) && (run_cnt_q < RUN_MAX);
`endif

    // Next-state, counters and next output word; the default output is a comma.
    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        run_cnt_d   = run_cnt_q;
        ctrl_d      = CTRL_K;
        data_d      = COMMA_WORD;
        link_d      = link_q;
        take_s      = 1'b0;
        case (state_q)
            ST_ALIGN: begin
                align_cnt_d = align_cnt_q + AW'(1);
                if (align_cnt_q == ALIGN_LAST) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_DATA: begin
                link_d = 1'b1;
                if (word_avail_s && (run_cnt_q < RUN_MAX)) begin
                    take_s    = 1'b1;
                    ctrl_d    = CTRL_D;
                    data_d    = word_s;
                    run_cnt_d = run_cnt_q + RW'(1);
                    if ((run_cnt_q + RW'(1)) == RUN_MAX) begin
                        state_d = ST_COMMA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    run_cnt_d = '0;
                end
            end
            ST_COMMA: begin
                link_d    = 1'b1;
                run_cnt_d = '0;
                state_d   = ST_DATA;
            end
            default: begin
                state_d     = ST_ALIGN;
                align_cnt_d = '0;
                run_cnt_d   = '0;
                link_d      = 1'b0;
            end
        endcase
    end

    // State, counters and registered line outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_ALIGN;
            align_cnt_q <= '0;
            run_cnt_q   <= '0;
            ctrl_q      <= CTRL_K;
            data_q      <= COMMA_WORD;
            link_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            run_cnt_q   <= run_cnt_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            link_q      <= link_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign data_o    = data_q;
    assign link_up_o = link_q;

endmodule

// File: tb/tb_gtx_tx.sv
// Directed testbench for gtx_tx (default parameters).
// The source is a counter: data_i always shows the next word, and it advances
// only when a transfer happens (valid && ready).
module tb_gtx_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_i;
    logic        vld;
    logic        rdy;
    logic [1:0]  ctrl;
    logic [15:0] dout;
    logic        link;

    logic [15:0] src;
    int          fire_cnt;
    int          tests;
    int          fails;

    logic [1:0]  s_ctrl;
    logic [15:0] s_data;
    logic        s_rdy;
    logic        s_link;

    gtx_tx dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .data_i     (data_i),
        .data_vld_i (vld),
        .data_rdy_o (rdy),
        .ctrl_o     (ctrl),
        .data_o     (dout),
        .link_up_o  (link)
    );

    always #5 clk = ~clk;

    // Sample outputs mid-cycle, then advance one clock and update the source.
    task automatic cycle();
        logic fire;
        #1;
        s_ctrl = ctrl;
        s_data = dout;
        s_rdy  = rdy;
        s_link = link;
        fire   = vld && rdy;
        @(posedge clk);
        if (fire) begin
            src      = src + 16'd1;
            fire_cnt = fire_cnt + 1;
        end
        #1;
        data_i = src;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (ctrl !== 2'b11 || dout !== 16'hBCBC) begin
            fails++;
            $display("FAIL reset_word got %b/%h exp 11/bcbc", ctrl, dout);
        end
        tests++;
        if (rdy !== 1'b0 || link !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got rdy=%b link=%b exp 0/0", rdy, link);
        end
    endtask

    task automatic test_align(input string name);
        logic [15:0] exp;
        exp = src;
        for (int k = 0; k < 16; k++) begin
            cycle();
            tests++;
            if (s_ctrl !== 2'b11 || s_data !== 16'hBCBC || s_link !== 1'b0) begin
                fails++;
                $display("FAIL %s_comma[%0d] got %b/%h link=%b exp 11/bcbc link=0",
                         name, k, s_ctrl, s_data, s_link);
            end
`ifndef GTX_TX_FIFO_EN
            tests++;
            if (s_rdy !== (k == 15)) begin
                fails++;
                $display("FAIL %s_rdy[%0d] got %b exp %b", name, k, s_rdy, (k == 15));
            end
`endif
        end
        cycle();
        tests++;
        if (s_ctrl !== 2'b00 || s_data !== exp || s_link !== 1'b1) begin
            fails++;
            $display("FAIL %s_first got %b/%h link=%b exp 00/%h link=1",
                     name, s_ctrl, s_data, s_link, exp);
        end
    endtask

    task automatic test_stream();
        for (int i = 1; i < 256; i++) begin
            cycle();
            tests++;
            if (s_ctrl !== 2'b00 || s_data !== 16'(i)) begin
                fails++;
                $display("FAIL stream[%0d] got %b/%h exp 00/%h", i, s_ctrl, s_data, 16'(i));
            end
        end
        tests++;
        if (s_rdy !== 1'b0) begin
            fails++;
            $display("FAIL stream_rdy_at_limit got %b exp 0", s_rdy);
        end
        cycle();
        tests++;
        if (s_ctrl !== 2'b11 || s_data !== 16'hBCBC) begin
            fails++;
            $display("FAIL stream_forced_comma got %b/%h exp 11/bcbc", s_ctrl, s_data);
        end
        cycle();
        tests++;
        if (s_ctrl !== 2'b00 || s_data !== 16'h0100) begin
            fails++;
            $display("FAIL stream_resume got %b/%h exp 00/0100", s_ctrl, s_data);
        end
    endtask

    task automatic test_idle();
        vld = 1'b0;
        cycle();
        tests++;
        if (s_ctrl !== 2'b00 || s_data !== 16'h0101) begin
            fails++;
            $display("FAIL idle_last_word got %b/%h exp 00/0101", s_ctrl, s_data);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) vld = 1'b1;
            cycle();
            tests++;
            if (s_ctrl !== 2'b11 || s_data !== 16'hBCBC) begin
                fails++;
                $display("FAIL idle_comma[%0d] got %b/%h exp 11/bcbc", k, s_ctrl, s_data);
            end
        end
        for (int i = 0; i < 256; i++) begin
            cycle();
            tests++;
            if (s_ctrl !== 2'b00 || s_data !== 16'(16'h0102 + i)) begin
                fails++;
                $display("FAIL idle_run[%0d] got %b/%h exp 00/%h",
                         i, s_ctrl, s_data, 16'(16'h0102 + i));
            end
        end
        cycle();
        tests++;
        if (s_ctrl !== 2'b11 || s_data !== 16'hBCBC) begin
            fails++;
            $display("FAIL idle_forced_comma got %b/%h exp 11/bcbc", s_ctrl, s_data);
        end
        cycle();
        tests++;
        if (s_ctrl !== 2'b00 || s_data !== 16'h0202) begin
            fails++;
            $display("FAIL idle_resume got %b/%h exp 00/0202", s_ctrl, s_data);
        end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_align("realign");
    endtask

`ifdef GTX_TX_FIFO_EN
    task automatic test_fifo_align();
        int          f0;
        logic [15:0] exp;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp   = src;
        f0    = fire_cnt;
        for (int k = 0; k < 16; k++) begin
            cycle();
        end
        tests++;
        if (fire_cnt - f0 !== 4 || s_rdy !== 1'b0) begin
            fails++;
            $display("FAIL fifo_fill got %0d accepted rdy=%b exp 4 rdy=0", fire_cnt - f0, s_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            tests++;
            if (s_ctrl !== 2'b00 || s_data !== 16'(exp + i)) begin
                fails++;
                $display("FAIL fifo_first[%0d] got %b/%h exp 00/%h",
                         i, s_ctrl, s_data, 16'(exp + i));
            end
        end
    endtask
`endif

    task automatic test_loopback();
        logic [15:0] rx_exp;
        logic        locked;
        int          rx_cnt;
        int          f0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rx_exp = src;
        f0     = fire_cnt;
        locked = 1'b0;
        rx_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            vld = (i < 650) ? ($urandom_range(0, 3) != 0) : 1'b0;
            cycle();
            if (s_ctrl == 2'b11 && s_data == 16'hBCBC) begin
                locked = 1'b1;
            end else if (s_ctrl == 2'b00) begin
                if (locked) begin
                    tests++;
                    if (s_data !== rx_exp) begin
                        fails++;
                        $display("FAIL loopback_word[%0d] got %h exp %h", rx_cnt, s_data, rx_exp);
                    end
                    rx_exp = rx_exp + 16'd1;
                    rx_cnt++;
                end
            end else begin
                tests++;
                fails++;
                $display("FAIL loopback_illegal got %b/%h exp 00/xxxx or 11/bcbc", s_ctrl, s_data);
            end
        end
        tests++;
        if (rx_cnt !== fire_cnt - f0 || rx_cnt == 0) begin
            fails++;
            $display("FAIL loopback_count got %0d exp %0d", rx_cnt, fire_cnt - f0);
        end
        vld = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        vld      = 1'b0;
        src      = 16'h0000;
        data_i   = 16'h0000;
        fire_cnt = 0;
        tests    = 0;
        fails    = 0;
        repeat (3) @(posedge clk);
        #1;
        vld = 1'b1;
        test_reset();
`ifdef GTX_TX_FIFO_EN
        test_fifo_align();
`else
        #1;
        rst_n = 1'b1;
        test_align("align");
        test_stream();
        test_idle();
        test_mid_reset();
`endif
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
